serial_add_seq: RTL and testbench

// - Bit-serial sequencer that feeds the team's 1-bit full-adder stage.
// - Takes two WIDTH-bit operands plus a carry-in, and presents one bit pair per cycle, LSB first, to the external full adder.
// - Holds the running carry in a flip-flop and collects the sum bits into a WIDTH-bit result with carry-out.
// - Sits directly upstream of the full adder and also consumes its sum and carry outputs.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/shift_reg_lsb.sv | 34 +++
 rtl/serial_add_seq.sv | 137 +++++++++++++
 tb/tb_serial_add_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   WIDTH_DEFAULT : default operand/result width
//   S_IDLE/S_RUN/S_DONE : sequencer state encoding
//   cnt_width()   : bit counter width for a given operand width
package serial_add_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The counter must index WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/shift_reg_lsb.sv
// Right-shifting register with parallel load. The serial input enters at
// the MSB, and the LSB is the bit presented downstream.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears q)
//   load      : parallel load of load_val (takes priority over shift)
//   load_val  : parallel load data
//   shift     : shift right one place, ser_in into the MSB
//   ser_in    : serial input bit
//   q         : register contents
module shift_reg_lsb
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {ser_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial addition sequencer. It feeds an external 1-bit full adder one
// operand bit pair per cycle, LSB first, keeps the running carry in a
// flip-flop and assembles the returned sum bits into a WIDTH-bit result.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, a, b, cin  : request and operands, captured when start & ready
//   ready, busy, done : status (IDLE/DONE, RUN, one-cycle DONE pulse)
//   sum, cout         : registered result, held until the next accepted start
//   fa_a, fa_b, fa_cin: bits presented to the full adder (0 outside RUN)
//   fa_sum, fa_cout   : full adder outputs (combinational return path)
//   state_dbg         : current sequencer state
//
// Handshake: a request is accepted on a rising edge where start & ready are
// both 1; a, b and cin are sampled on that same edge. ready depends only on
// state, never on start. While ready=0 start is ignored. done pulses for one
// cycle, and sum/cout are valid from that cycle until the next acceptance.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic [1:0]       state_dbg
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             accept;
    logic             running;
    logic             last_bit;

    assign accept   = start & ready;
    assign running  = (state == S_RUN);
    assign last_bit = running && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the adder sees 0+0+0 outside RUN.
    always_comb begin
        ready  = (state == S_IDLE) || (state == S_DONE);
        busy   = running;
        done   = (state == S_DONE);
        fa_a   = running ? a_sh[0] : 1'b0;
        fa_b   = running ? b_sh[0] : 1'b0;
        fa_cin = running ? carry   : 1'b0;
    end

    assign state_dbg = state;

    shift_reg_lsb #(.WIDTH(WIDTH)) u_a_sh (
        .clk(clk), .rst(rst), .load(accept), .load_val(a),
        .shift(running), .ser_in(1'b0), .q(a_sh)
    );

    shift_reg_lsb #(.WIDTH(WIDTH)) u_b_sh (
        .clk(clk), .rst(rst), .load(accept), .load_val(b),
        .shift(running), .ser_in(1'b0), .q(b_sh)
    );

    // Sum bits arrive LSB first, so after WIDTH shifts bit 0 sits at the LSB.
    shift_reg_lsb #(.WIDTH(WIDTH)) u_sum_sh (
        .clk(clk), .rst(rst), .load(accept), .load_val('0),
        .shift(running), .ser_in(fa_sum), .q(sum_sh)
    );

    // Running carry and bit counter. The counter holds on the last bit so it
    // never wraps; it is reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            carry <= cin;
            cnt   <= '0;
        end else if (running) begin
            carry <= fa_cout;
            if (!last_bit) cnt <= cnt + 1'b1;
        end
    end

    // Result registers: cleared on acceptance, so during a DONE+start cycle
    // the old result stays visible and clears at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= {fa_sum, sum_sh[WIDTH-1:1]};
            cout <= fa_cout;
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
  logic [1:0]   state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // External 1-bit full adder
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one request for one cycle, then scrambles operands during RUN.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Counts cycles after the accepting edge until done (0 = timed out).
  task automatic wait_done(output int lat, output int busy_n, output logic first_cin);
    lat = 0; busy_n = 0; first_cin = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) first_cin = fa_cin;
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '1; b = '1; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if (state_dbg !== serial_add_pkg::S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, serial_add_pkg::S_IDLE); end
    n_vec++; if ({ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL reset_flags: got rdy/busy/done=%b want 100", {ready, busy, done}); end
    n_vec++; if ({cout, sum} !== '0) begin n_err++; $display("FAIL reset_result: got cout=%b sum=%h want 0/00", cout, sum); end
    n_vec++; if ({fa_a, fa_b, fa_cin} !== 3'b000) begin n_err++; $display("FAIL idle_fa: got %b want 000", {fa_a, fa_b, fa_cin}); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [W-1:0] vb [3] = '{8'hA5, 8'h01, 8'hFF};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W:0]   exp;
    int           lat, bn;
    logic         fc;
    for (int k = 0; k < 3; k++) begin
      exp = ref_add(va[k], vb[k], vc[k]);
      launch(va[k], vb[k], vc[k]);
      wait_done(lat, bn, fc);
      n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, W + 1); end
      n_vec++; if (bn !== W) begin n_err++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", k, bn, W); end
      n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL dir%0d_result: got %h want %h", k, {cout, sum}, exp); end
      n_vec++; if (fc !== vc[k]) begin n_err++; $display("FAIL dir%0d_first_fa_cin: got %b want %b", k, fc, vc[k]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb_v;
    logic         tc;
    logic [W:0]   exp;
    int           lat, bn;
    logic         fc;
    for (int k = 0; k < 24; k++) begin
      ta = W'($urandom); tb_v = W'($urandom); tc = 1'($urandom_range(0, 1));
      exp = ref_add(ta, tb_v, tc);
      launch(ta, tb_v, tc);
      wait_done(lat, bn, fc);
      n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, W + 1); end
      n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL rnd%0d_result: %h+%h+%b got %h want %h", k, ta, tb_v, tc, {cout, sum}, exp); end
    end
  endtask

  task automatic test_start_ignored();
    logic [W:0] exp;
    int         lat;
    exp = ref_add(8'h12, 8'h34, 1'b1);
    launch(8'h12, 8'h34, 1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ign_ready_in_run: got %b want 0", ready); end
    start = 1'b1; a = 8'hEE; b = 8'hEE; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 4; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL ign_latency: got %0d want %0d", lat, W + 1); end
    n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL ign_result: got %h want %h", {cout, sum}, exp); end
  endtask

  task automatic test_reset_mid_run();
    int saw_done;
    launch(8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if (state_dbg !== serial_add_pkg::S_IDLE) begin n_err++; $display("FAIL rstrun_state: got %0d want %0d", state_dbg, serial_add_pkg::S_IDLE); end
    n_vec++; if ({ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL rstrun_flags: got rdy/busy/done=%b want 100", {ready, busy, done}); end
    n_vec++; if ({cout, sum} !== '0) begin n_err++; $display("FAIL rstrun_result: got %h want 000", {cout, sum}); end
    saw_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    n_vec++; if (saw_done !== 0) begin n_err++; $display("FAIL rstrun_no_done: got %0d pulses want 0", saw_done); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp;
    int         first_at, second_at;
    logic [W:0] first_res, second_res;
    logic [W:0] mid_res;
    logic       mid_busy;
    exp = ref_add(8'h10, 8'h20, 1'b0);
    first_at = 0; second_at = 0; first_res = '0; second_res = '0;
    mid_res = '1; mid_busy = 1'b0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == W + 2) begin mid_res = {cout, sum}; mid_busy = busy; end
      if (done && first_at == 0) begin
        first_at = i; first_res = {cout, sum};
      end else if (done) begin
        second_at = i; second_res = {cout, sum};
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    n_vec++; if (first_at !== W + 1) begin n_err++; $display("FAIL b2b_first_done: got %0d want %0d", first_at, W + 1); end
    n_vec++; if (first_res !== exp) begin n_err++; $display("FAIL b2b_first_result: got %h want %h", first_res, exp); end
    n_vec++; if ({mid_busy, mid_res} !== {1'b1, {(W+1){1'b0}}}) begin n_err++; $display("FAIL b2b_restart: got busy=%b res=%h want 1/000", mid_busy, mid_res); end
    n_vec++; if (second_at !== 2 * (W + 1)) begin n_err++; $display("FAIL b2b_second_done: got %0d want %0d", second_at, 2 * (W + 1)); end
    n_vec++; if (second_res !== exp) begin n_err++; $display("FAIL b2b_second_result: got %h want %h", second_res, exp); end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
